// File: rtl/mmio_pkg.sv
// Shared constants and address decode for the MMIO store-capture peripheral.
package mmio_pkg;

  localparam int unsigned STATUS_CLR_BIT  = 0;
  localparam int unsigned STATUS_FULL_BIT = 16;
  localparam int unsigned STATUS_OVF_BIT  = 17;
  localparam int unsigned STATUS_DROP_LSB = 24;

  typedef struct packed {
    logic       ch_hit;
    logic       st_hit;
    logic [3:0] idx;
  } decode_t;

  // Word-aligned window: NUM_CH channel registers followed by one STATUS word.
  function automatic decode_t ch_index(input logic [63:0] addr, input logic [63:0] base,
                                       input int unsigned num_ch);
    decode_t     res;
    logic [63:0] word;
    res  = '0;
    word = (addr - base) >> 2;
    if (addr[1:0] == 2'b00 && addr >= base) begin
      if (word < 64'(num_ch)) begin
        res.ch_hit = 1'b1;
        res.idx    = word[3:0];
      end else if (word == 64'(num_ch)) begin
        res.st_hit = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mmio_store_capture_if.sv
// Data-bus and output-stream signals of the store-capture peripheral.
interface mmio_store_capture_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CH_W   = 2
);
  logic              mem;
  logic              mem_read;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              hit;
  logic              out_valid;
  logic              out_ready;
  logic [CH_W-1:0]   out_ch;
  logic [DATA_W-1:0] out_data;
  logic              overflow;

  modport slave (
    input  mem, mem_read, addr, wdata, out_ready,
    output rdata, hit, out_valid, out_ch, out_data, overflow
  );

  modport master (
    output mem, mem_read, addr, wdata, out_ready,
    input  rdata, hit, out_valid, out_ch, out_data, overflow
  );
endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered storage; push while full is accepted only with a pop.
module sync_fifo #(
  parameter int unsigned WIDTH = 34,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           din_i,
  output logic [WIDTH-1:0]           dout_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign dout_o  = mem_q[rptr_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      count_q <= count_d;
      if (do_push) begin
        mem_q[wptr_q] <= din_i;
        wptr_q        <= wptr_q + PW'(1);
      end
      if (do_pop) rptr_q <= rptr_q + PW'(1);
    end
  end

endmodule

// File: rtl/mmio_store_capture.sv
// Memory-mapped store capture: channel shadows, STATUS word and a FIFO drained as a stream.
module mmio_store_capture
  import mmio_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned BASE   = 1024,
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  mmio_store_capture_if.slave  bus
);
  localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned COUNT_W = $clog2(DEPTH + 1);
  localparam int unsigned ENTRY_W = CH_W + DATA_W;

  decode_t              dec;
  logic                 rd, wr_ch, wr_st;
  logic                 push, pop, drop, clr;
  logic                 full, empty;
  logic [COUNT_W-1:0]   count;
  logic [ENTRY_W-1:0]   head;
  logic [CH_W-1:0]      wr_idx;
  logic [DATA_W-1:0]    shadow_q [NUM_CH];
  logic                 overflow_q, overflow_d;
  logic [7:0]           drop_cnt_q, drop_cnt_d;
  logic [DATA_W-1:0]    ch_rdata, status;

  assign dec    = ch_index(64'(bus.addr), 64'(BASE), NUM_CH);
  assign wr_idx = dec.idx[CH_W-1:0];
  assign rd     = bus.mem & bus.mem_read;
  assign wr_ch  = bus.mem & ~bus.mem_read & dec.ch_hit;
  assign wr_st  = bus.mem & ~bus.mem_read & dec.st_hit;
  assign clr    = wr_st & bus.wdata[STATUS_CLR_BIT];

  assign pop    = ~empty & bus.out_ready;
  assign push   = wr_ch & (~full | pop);
  assign drop   = wr_ch & full & ~pop;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   ({wr_idx, bus.wdata}),
    .dout_o  (head),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  assign bus.out_valid = ~empty;
  assign bus.out_ch    = head[ENTRY_W-1 -: CH_W];
  assign bus.out_data  = head[DATA_W-1:0];
  assign bus.overflow  = overflow_q;
  assign bus.hit       = dec.ch_hit | dec.st_hit;

  always_comb begin
    ch_rdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (dec.idx == 4'(i)) ch_rdata = shadow_q[i];
    end
  end

  always_comb begin
    status                            = '0;
    status[COUNT_W-1:0]               = count;
    status[STATUS_FULL_BIT]           = full;
    status[STATUS_OVF_BIT]            = overflow_q;
    status[STATUS_DROP_LSB +: 8]      = drop_cnt_q;
  end

  always_comb begin
    bus.rdata = '0;
    if (rd && dec.ch_hit)      bus.rdata = ch_rdata;
    else if (rd && dec.st_hit) bus.rdata = status;
  end

  // Clear is applied first so a same-cycle drop still leaves overflow=1, drop_cnt=1.
  always_comb begin
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (clr) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end
    if (drop) begin
      overflow_d = 1'b1;
      drop_cnt_d = (drop_cnt_d == 8'hFF) ? 8'hFF : drop_cnt_d + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
      for (int i = 0; i < NUM_CH; i++) shadow_q[i] <= '0;
    end else begin
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_ch && dec.idx == 4'(i)) shadow_q[i] <= bus.wdata;
      end
    end
  end

endmodule

// File: tb/tb_mmio_store_capture.sv
// Directed self-checking bench for mmio_store_capture (DATA_W=32, NUM_CH=4, DEPTH=8, BASE=1024).
module tb_mmio_store_capture;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;
  logic [31:0] rd;
  logic        h;

  mmio_store_capture_if #(.DATA_W(32), .ADDR_W(32), .CH_W(2)) bus ();

  mmio_store_capture #(
    .DATA_W (32),
    .ADDR_W (32),
    .BASE   (1024),
    .NUM_CH (4),
    .DEPTH  (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic bus_store(input logic [31:0] a, input logic [31:0] d);
    bus.mem      = 1'b1;
    bus.mem_read = 1'b0;
    bus.addr     = a;
    bus.wdata    = d;
    @(posedge clk);
    #1;
    bus.mem      = 1'b0;
  endtask

  task automatic bus_load(input logic [31:0] a, output logic [31:0] d, output logic hh);
    bus.mem      = 1'b1;
    bus.mem_read = 1'b1;
    bus.addr     = a;
    #1;
    d            = bus.rdata;
    hh           = bus.hit;
    bus.mem      = 1'b0;
    bus.mem_read = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    n_total++; if (bus.out_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", bus.out_valid); else n_pass++;
    n_total++; if (bus.out_ch !== 2'd0) $display("FAIL rst_ch: got %0d want 0", bus.out_ch); else n_pass++;
    n_total++; if (bus.out_data !== 32'd0) $display("FAIL rst_data: got %h want 0", bus.out_data); else n_pass++;
    n_total++; if (bus.overflow !== 1'b0) $display("FAIL rst_ovf: got %b want 0", bus.overflow); else n_pass++;
    bus_load(32'd1040, rd, h);
    n_total++; if (rd !== 32'h0 || h !== 1'b1) $display("FAIL rst_status: got %h/%b want 0/1", rd, h); else n_pass++;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_total++; if (bus.out_valid !== 1'b0) $display("FAIL rst_post_valid: got %b want 0", bus.out_valid); else n_pass++;
  endtask

  task automatic test_store_basic();
    bus.out_ready = 1'b0;
    bus_store(32'd1024, 32'h0000_00AA);
    n_total++; if (bus.out_valid !== 1'b1) $display("FAIL basic_valid: got %b want 1", bus.out_valid); else n_pass++;
    n_total++; if (bus.out_ch !== 2'd0 || bus.out_data !== 32'hAA)
      $display("FAIL basic_head: got %0d/%h want 0/000000aa", bus.out_ch, bus.out_data); else n_pass++;
    bus_store(32'd1028, 32'h0000_0055);
    bus_load(32'd1040, rd, h);
    n_total++; if (rd !== 32'h0000_0002) $display("FAIL basic_status: got %h want 00000002", rd); else n_pass++;
    bus_load(32'd1024, rd, h);
    n_total++; if (rd !== 32'hAA || h !== 1'b1) $display("FAIL basic_rd_ch0: got %h/%b want aa/1", rd, h); else n_pass++;
    bus_load(32'd1028, rd, h);
    n_total++; if (rd !== 32'h55) $display("FAIL basic_rd_ch1: got %h want 55", rd); else n_pass++;
  endtask

  task automatic test_drain();
    bus.out_ready = 1'b1;
    #1;
    n_total++; if (bus.out_ch !== 2'd0 || bus.out_data !== 32'hAA)
      $display("FAIL drain_0: got %0d/%h want 0/000000aa", bus.out_ch, bus.out_data); else n_pass++;
    @(posedge clk);
    #1;
    n_total++; if (bus.out_valid !== 1'b1 || bus.out_ch !== 2'd1 || bus.out_data !== 32'h55)
      $display("FAIL drain_1: got %b/%0d/%h want 1/1/00000055", bus.out_valid, bus.out_ch, bus.out_data);
    else n_pass++;
    @(posedge clk);
    #1;
    n_total++; if (bus.out_valid !== 1'b0) $display("FAIL drain_empty: got %b want 0", bus.out_valid); else n_pass++;
    bus.out_ready = 1'b0;
    bus_load(32'd1040, rd, h);
    n_total++; if (rd !== 32'h0) $display("FAIL drain_status: got %h want 0", rd); else n_pass++;
  endtask

  task automatic test_overflow();
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 10; i++) bus_store(32'd1036, 32'(i));
    bus_load(32'd1040, rd, h);
    n_total++; if (rd !== 32'h0203_0008) $display("FAIL ovf_status: got %h want 02030008", rd); else n_pass++;
    n_total++; if (bus.overflow !== 1'b1) $display("FAIL ovf_flag: got %b want 1", bus.overflow); else n_pass++;
    bus_load(32'd1036, rd, h);
    n_total++; if (rd !== 32'd10) $display("FAIL ovf_shadow3: got %h want 0000000a", rd); else n_pass++;
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      #1;
      n_total++; if (bus.out_valid !== 1'b1 || bus.out_ch !== 2'd3 || bus.out_data !== 32'(i))
        $display("FAIL ovf_drain_%0d: got %b/%0d/%h want 1/3/%h", i, bus.out_valid, bus.out_ch,
                 bus.out_data, 32'(i));
      else n_pass++;
      @(posedge clk);
    end
    #1;
    bus.out_ready = 1'b0;
    n_total++; if (bus.out_valid !== 1'b0) $display("FAIL ovf_empty: got %b want 0", bus.out_valid); else n_pass++;
    bus_store(32'd1040, 32'h1);
    bus_load(32'd1040, rd, h);
    n_total++; if (rd !== 32'h0) $display("FAIL ovf_cleared: got %h want 0", rd); else n_pass++;
  endtask

  task automatic test_full_pop();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) bus_store(32'd1032, 32'h100 + 32'(i));
    bus.out_ready = 1'b1;
    bus_store(32'd1032, 32'h1FF);
    bus.out_ready = 1'b0;
    bus_load(32'd1040, rd, h);
    n_total++; if (rd !== 32'h0001_0008) $display("FAIL fullpop_status: got %h want 00010008", rd); else n_pass++;
    n_total++; if (bus.overflow !== 1'b0) $display("FAIL fullpop_ovf: got %b want 0", bus.overflow); else n_pass++;
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      #1;
      n_total++; if (bus.out_ch !== 2'd2 || bus.out_data !== ((i == 8) ? 32'h1FF : 32'h100 + 32'(i)))
        $display("FAIL fullpop_drain_%0d: got %0d/%h", i, bus.out_ch, bus.out_data);
      else n_pass++;
      @(posedge clk);
    end
    #1;
    bus.out_ready = 1'b0;
    n_total++; if (bus.out_valid !== 1'b0) $display("FAIL fullpop_empty: got %b want 0", bus.out_valid); else n_pass++;
  endtask

  task automatic test_clear_race();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) bus_store(32'd1028, 32'h10 + 32'(i));
    bus_store(32'd1028, 32'h99);
    bus_load(32'd1040, rd, h);
    n_total++; if (rd !== 32'h0103_0008) $display("FAIL clr_one_drop: got %h want 01030008", rd); else n_pass++;
    bus_load(32'd1028, rd, h);
    n_total++; if (rd !== 32'h99) $display("FAIL clr_shadow1: got %h want 00000099", rd); else n_pass++;
    bus_store(32'd1040, 32'h2);
    bus_load(32'd1040, rd, h);
    n_total++; if (rd !== 32'h0103_0008) $display("FAIL clr_noop: got %h want 01030008", rd); else n_pass++;
    bus_store(32'd1040, 32'h1);
    bus_load(32'd1040, rd, h);
    n_total++; if (rd !== 32'h0001_0008) $display("FAIL clr_clear: got %h want 00010008", rd); else n_pass++;
    n_total++; if (bus.overflow !== 1'b0) $display("FAIL clr_ovf: got %b want 0", bus.overflow); else n_pass++;
    for (int i = 0; i < 260; i++) bus_store(32'd1028, 32'(i));
    bus_load(32'd1040, rd, h);
    n_total++; if (rd !== 32'hFF03_0008) $display("FAIL clr_saturate: got %h want ff030008", rd); else n_pass++;
    n_total++; if (bus.out_data !== 32'h10 || bus.out_ch !== 2'd1)
      $display("FAIL clr_head: got %0d/%h want 1/00000010", bus.out_ch, bus.out_data); else n_pass++;
    bus_store(32'd1040, 32'h1);
    bus_load(32'd1040, rd, h);
    n_total++; if (rd !== 32'h0001_0008) $display("FAIL clr_clear2: got %h want 00010008", rd); else n_pass++;
    bus.out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    n_total++; if (bus.out_valid !== 1'b0) $display("FAIL clr_drained: got %b want 0", bus.out_valid); else n_pass++;
  endtask

  task automatic test_misc_reset();
    bus.out_ready = 1'b0;
    bus.mem = 1'b1; bus.mem_read = 1'b0; bus.addr = 32'd1025; bus.wdata = 32'hDEAD;
    #1;
    n_total++; if (bus.hit !== 1'b0) $display("FAIL misc_hit_1025: got %b want 0", bus.hit); else n_pass++;
    n_total++; if (bus.rdata !== 32'h0) $display("FAIL misc_rdata_store: got %h want 0", bus.rdata); else n_pass++;
    @(posedge clk);
    #1;
    bus_store(32'd1044, 32'hBEEF);
    n_total++; if (bus.out_valid !== 1'b0) $display("FAIL misc_nopush: got %b want 0", bus.out_valid); else n_pass++;
    bus_load(32'd1044, rd, h);
    n_total++; if (rd !== 32'h0 || h !== 1'b0) $display("FAIL misc_rd_1044: got %h/%b want 0/0", rd, h); else n_pass++;
    bus_load(32'd1024, rd, h);
    n_total++; if (rd !== 32'hAA) $display("FAIL misc_shadow0: got %h want 000000aa", rd); else n_pass++;
    bus_store(32'd1024, 32'h1);
    bus_store(32'd1028, 32'h2);
    bus_store(32'd1032, 32'h3);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    n_total++; if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0)
      $display("FAIL misc_rst_async: got %b/%h want 0/0", bus.out_valid, bus.out_data); else n_pass++;
    bus_load(32'd1040, rd, h);
    n_total++; if (rd !== 32'h0) $display("FAIL misc_rst_status: got %h want 0", rd); else n_pass++;
    bus_load(32'd1024, rd, h);
    n_total++; if (rd !== 32'h0) $display("FAIL misc_rst_shadow: got %h want 0", rd); else n_pass++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    n_total++; if (bus.out_valid !== 1'b0) $display("FAIL misc_post_rst: got %b want 0", bus.out_valid); else n_pass++;
  endtask

  initial begin
    n_pass        = 0;
    n_total       = 0;
    rst           = 1'b1;
    bus.mem       = 1'b0;
    bus.mem_read  = 1'b0;
    bus.addr      = '0;
    bus.wdata     = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_store_basic();
    test_drain();
    test_overflow();
    test_full_pop();
    test_clear_race();
    test_misc_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mmio_store_capture.md
Name: mmio_store_capture

Overview:
- Synthesizable memory-mapped capture peripheral on the furv data bus (mem, mem_read, addr, core write data, core read data).
- Generalises the single fixed "print on store to 1024" address into NUM_CH channel registers in a window starting at BASE.
- Every accepted store is queued as {channel, data} in a DEPTH-entry FIFO and drained over a valid/ready stream to a host, UART bridge or bench monitor.
- Adds read-back, full/overflow status and a drop counter.

Parameters:
- DATA_W, 32, bus data width; must be >= 32.
- ADDR_W, 32, bus address width.
- BASE, 1024, byte address of channel 0; must be 4-aligned.
- NUM_CH, 4, number of channel registers, 1..16.
- DEPTH, 8, FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- mem  in  1  bus access strobe for this cycle
- mem_read  in  1  1 = load, 0 = store (qualified by mem)
- addr  in  ADDR_W  byte address
- wdata  in  DATA_W  store data (core data_out)
- rdata  out  DATA_W  load data (core data_in)
- hit  out  1  addr decodes to this block
- out_valid  out  1  FIFO head is valid
- out_ready  in  1  consumer accepts head
- out_ch  out  $clog2(NUM_CH) (min 1)  channel of head entry
- out_data  out  DATA_W  data of head entry
- overflow  out  1  sticky drop flag

Behaviour:
- Decode:
  - Channel i at BASE+4*i, for i < NUM_CH.
  - STATUS at BASE+4*NUM_CH.
  - addr[1:0] != 0 or outside the window: hit=0, no effect, rdata=0.
- hit, rdata combinational. rdata=0 unless mem & mem_read & hit.
- Channel read returns shadow[i], the last value stored to channel i.
- STATUS read layout:
  - [COUNT_W-1:0] = count, where COUNT_W = $clog2(DEPTH+1)
  - [16] = full
  - [17] = overflow
  - [31:24] = drop_cnt
  - all other bits 0
- Channel store (mem & !mem_read & channel hit), at posedge:
  - shadow[i] <= wdata unconditionally.
  - Push {i, wdata} if a slot is free.
- Full-FIFO store:
  - With a simultaneous pop (out_valid & out_ready): push accepted, count unchanged, no drop.
  - Without a pop: entry dropped; overflow <= 1; drop_cnt <= drop_cnt+1, saturating at 255.
- STATUS store with wdata[0]=1 clears overflow and drop_cnt. If a drop occurs in the same cycle, the set/increment wins: overflow=1, drop_cnt=1.
- STATUS store with wdata[0]=0: no effect.
- Stream side:
  - out_valid = (count != 0).
  - out_ch and out_data are registered FIFO head values, stable while out_valid & !out_ready.
  - Pop on out_valid & out_ready.
  - Push-to-valid latency is 1 cycle; there is no bypass when empty. A store at edge N gives out_valid=1 after edge N.
  - out_ready while empty is ignored.
- Pointers:
  - $clog2(DEPTH)-bit read and write pointers, wrap naturally.
  - count tracked separately, 0..DEPTH.
  - full = (count == DEPTH).
- Ordering: FIFO order equals bus store order across all channels.
- Reset (asynchronous, any time, including mid-drain):
  - count=0, pointers=0, shadows=0, overflow=0, drop_cnt=0
  - out_valid=0, out_ch=0, out_data=0
  - In-flight entries are discarded.
- Loads never alter state.

Decomposition:
- Package mmio_pkg:
  - STATUS_FULL_BIT=16, STATUS_OVF_BIT=17, STATUS_DROP_LSB=24
  - STATUS_CLR_BIT=0
  - function ch_index(addr, BASE) returning channel/valid decode
- Sub-module sync_fifo (WIDTH, DEPTH):
  - push, pop, din, dout, count, full, empty
  - Simultaneous push+pop when full is allowed.
- mmio_store_capture instantiates sync_fifo with WIDTH = $clog2(NUM_CH)+DATA_W, and holds the decode, shadows and status logic.

Test Plan:
- Reset release, then store 0x000000AA to 1024 and 0x55 to 1028 with out_ready=0. Expected: out_valid rises 1 cycle after first store; STATUS read count=2; channel reads return 0xAA and 0x55.
- Drain with out_ready=1. Expected: (ch0, 0xAA) then (ch1, 0x55) on consecutive cycles; then out_valid=0; STATUS count=0.
- 10 stores to ch3 (values 1..10), out_ready=0, DEPTH=8. Expected: count=8, full=1, overflow=1, drop_cnt=2; drain yields 1..8; shadow[3]=10.
- FIFO full, store to ch2 with out_ready=1 in the same cycle. Expected: no drop, count stays 8, new entry is last in drain order.
- Store wdata=1 to STATUS (1040) in the same cycle as a drop. Expected: overflow=1, drop_cnt=1. Next clear store gives overflow=0, drop_cnt=0.
- Misaligned store to 1025, store to 1044, and assertion of rst mid-drain. Expected: the two stores give hit=0 with no push; rst gives out_valid=0 and count=0 immediately, before the next clock edge.
